vx_alu_commit_merge: RTL

//  Downstream neighbour of the ALU unit's per-block response arbiter. Takes partial-bandwidth

---
 rtl/vx_alu_commit_merge.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/vx_alu_commit_merge.sv
// Reassembles partial-width ALU commit beats (pid/sop/eop tagged) into one full-width commit packet.
// Optional protocol checking is enabled by defining COMMIT_MERGE_CHECK_EN.
module vx_alu_commit_merge #(
  parameter int NUM_LANES   = 4,
  parameter int NUM_THREADS = 16,
  parameter int XLEN        = 32,
  parameter int UUID_W      = 44,
  parameter int NW_W        = 2,
  parameter int PC_W        = 30,
  parameter int NR_W        = 6,
  localparam int NUM_GRPS   = NUM_THREADS / NUM_LANES,
  localparam int PID_W      = (NUM_GRPS > 1) ? $clog2(NUM_GRPS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [UUID_W-1:0]           in_uuid,
  input  logic [NW_W-1:0]             in_wid,
  input  logic [NUM_LANES-1:0]        in_tmask,
  input  logic [PC_W-1:0]             in_pc,
  input  logic [NR_W-1:0]             in_rd,
  input  logic                        in_wb,
  input  logic [NUM_LANES*XLEN-1:0]   in_data,
  input  logic [PID_W-1:0]            in_pid,
  input  logic                        in_sop,
  input  logic                        in_eop,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [UUID_W-1:0]           out_uuid,
  output logic [NW_W-1:0]             out_wid,
  output logic [NUM_THREADS-1:0]      out_tmask,
  output logic [PC_W-1:0]             out_pc,
  output logic [NR_W-1:0]             out_rd,
  output logic                        out_wb,
  output logic [NUM_THREADS*XLEN-1:0] out_data,
  output logic                        err
);

  typedef enum logic [0:0] {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  state_t                      state_r, state_nxt_s;
  logic [UUID_W-1:0]           hdr_uuid_r, hdr_uuid_s;
  logic [NW_W-1:0]             hdr_wid_r, hdr_wid_s;
  logic [PC_W-1:0]             hdr_pc_r, hdr_pc_s;
  logic [NR_W-1:0]             hdr_rd_r, hdr_rd_s;
  logic                        hdr_wb_r, hdr_wb_s;
  logic [NUM_THREADS-1:0]      acc_tmask_r, mrg_tmask_s;
  logic [NUM_THREADS*XLEN-1:0] acc_data_r, mrg_data_s;
  logic [XLEN-1:0]             lane_s [NUM_LANES];
  logic [NUM_GRPS-1:0]         hit_s;
  logic                        fire_s, start_s, sop_s, eop_s, pid_ok_s, err_set_s;

  // A single-group configuration treats every beat as a complete instruction.
  assign sop_s    = (NUM_GRPS == 1) | in_sop;
  assign eop_s    = (NUM_GRPS == 1) | in_eop;
  assign start_s  = sop_s | (state_r == IDLE);
  assign pid_ok_s = (NUM_GRPS == 1) || (int'(in_pid) < NUM_GRPS);
  assign in_ready = ~eop_s | ~out_valid | out_ready;
  assign fire_s   = in_valid & in_ready;

  assign hdr_uuid_s = start_s ? in_uuid : hdr_uuid_r;
  assign hdr_wid_s  = start_s ? in_wid  : hdr_wid_r;
  assign hdr_pc_s   = start_s ? in_pc   : hdr_pc_r;
  assign hdr_rd_s   = start_s ? in_rd   : hdr_rd_r;
  assign hdr_wb_s   = start_s ? in_wb   : hdr_wb_r;

  // Masked lane data and the lane-group slot selected by this beat
  always_comb begin
    for (int k = 0; k < NUM_LANES; k++) begin
      lane_s[k] = in_tmask[k] ? in_data[k*XLEN +: XLEN] : {XLEN{1'b0}};
    end
    for (int g = 0; g < NUM_GRPS; g++) begin
      hit_s[g] = pid_ok_s && ((NUM_GRPS == 1) || (int'(in_pid) == g));
    end
  end

  // Merge this beat's lanes over the (possibly cleared) partial
  always_comb begin
    mrg_tmask_s = start_s ? {NUM_THREADS{1'b0}} : acc_tmask_r;
    mrg_data_s  = start_s ? {(NUM_THREADS*XLEN){1'b0}} : acc_data_r;
    for (int g = 0; g < NUM_GRPS; g++) begin
      for (int k = 0; k < NUM_LANES; k++) begin
        mrg_tmask_s[g*NUM_LANES+k] = hit_s[g] ? in_tmask[k] : mrg_tmask_s[g*NUM_LANES+k];
        mrg_data_s[(g*NUM_LANES+k)*XLEN +: XLEN] =
          hit_s[g] ? lane_s[k] : mrg_data_s[(g*NUM_LANES+k)*XLEN +: XLEN];
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    if (fire_s) begin
      state_nxt_s = eop_s ? IDLE : ACCUM;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_nxt_s;
  end

  // Accumulation register: header and partial lanes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hdr_uuid_r  <= {UUID_W{1'b0}};
      hdr_wid_r   <= {NW_W{1'b0}};
      hdr_pc_r    <= {PC_W{1'b0}};
      hdr_rd_r    <= {NR_W{1'b0}};
      hdr_wb_r    <= 1'b0;
      acc_tmask_r <= {NUM_THREADS{1'b0}};
      acc_data_r  <= {(NUM_THREADS*XLEN){1'b0}};
    end else if (fire_s) begin
      hdr_uuid_r  <= hdr_uuid_s;
      hdr_wid_r   <= hdr_wid_s;
      hdr_pc_r    <= hdr_pc_s;
      hdr_rd_r    <= hdr_rd_s;
      hdr_wb_r    <= hdr_wb_s;
      acc_tmask_r <= mrg_tmask_s;
      acc_data_r  <= mrg_data_s;
    end
  end

  // Output register; drain and reload may happen in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_uuid  <= {UUID_W{1'b0}};
      out_wid   <= {NW_W{1'b0}};
      out_pc    <= {PC_W{1'b0}};
      out_rd    <= {NR_W{1'b0}};
      out_wb    <= 1'b0;
      out_tmask <= {NUM_THREADS{1'b0}};
      out_data  <= {(NUM_THREADS*XLEN){1'b0}};
    end else if (fire_s && eop_s) begin
      out_valid <= 1'b1;
      out_uuid  <= hdr_uuid_s;
      out_wid   <= hdr_wid_s;
      out_pc    <= hdr_pc_s;
      out_rd    <= hdr_rd_s;
      out_wb    <= hdr_wb_s;
      out_tmask <= mrg_tmask_s;
      out_data  <= mrg_data_s;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef COMMIT_MERGE_CHECK_EN
  logic [NUM_GRPS-1:0] written_r, written_base_s;

  assign written_base_s = start_s ? {NUM_GRPS{1'b0}} : written_r;
  assign err_set_s = fire_s & (((state_r == ACCUM) & sop_s) |
                               ((state_r == IDLE) & ~sop_s) |
                               ((state_r == ACCUM) & ((in_wid != hdr_wid_r) | (in_uuid != hdr_uuid_r))) |
                               ~pid_ok_s |
                               (|(written_base_s & hit_s)));

  // Lane groups already delivered for the current instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       written_r <= {NUM_GRPS{1'b0}};
    else if (fire_s) written_r <= written_base_s | hit_s;
  end
`else
  assign err_set_s = 1'b0;
`endif

  // Sticky protocol error flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) err <= 1'b0;
    else       err <= err | err_set_s;
  end

endmodule
